// File: rtl/banco_registradores_if.sv
// Register-file access bus: one write port, two read ports, one debug read port.
// The master drives addresses/data; the slave (register file) returns registered read data.
interface banco_registradores_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              flag_escrita;
    logic [ADDR_W-1:0] endereco_escrita;
    logic [DATA_W-1:0] dado_escrita;
    logic              flag_leitura;
    logic [ADDR_W-1:0] endereco_leitura1;
    logic [ADDR_W-1:0] endereco_leitura2;
    logic [DATA_W-1:0] leitura1;
    logic [DATA_W-1:0] leitura2;
    logic [ADDR_W-1:0] endereco_debug;
    logic [DATA_W-1:0] saida_debug;
    logic              escrita_valida;

    modport master (
        output flag_escrita, endereco_escrita, dado_escrita,
        output flag_leitura, endereco_leitura1, endereco_leitura2,
        output endereco_debug,
        input  leitura1, leitura2, saida_debug, escrita_valida
    );

    modport slave (
        input  flag_escrita, endereco_escrita, dado_escrita,
        input  flag_leitura, endereco_leitura1, endereco_leitura2,
        input  endereco_debug,
        output leitura1, leitura2, saida_debug, escrita_valida
    );
endinterface

// File: rtl/banco_registradores.sv
// Processor register file: r0 hardwired to zero, write-first bypass on every read port,
// all outputs registered with one cycle of latency.
module banco_registradores #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic                   clock,
    input logic                   reset,
    banco_registradores_if.slave  bus
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    logic              escrita_ok_c;
    logic [DATA_W-1:0] leitura1_c;
    logic [DATA_W-1:0] leitura2_c;
    logic [DATA_W-1:0] debug_c;

    assign escrita_ok_c = bus.flag_escrita && (bus.endereco_escrita != '0);

    // Read selection: address 0 forces zero, a same-cycle write to the address wins.
    always_comb begin
        leitura1_c = '0;
        leitura2_c = '0;
        debug_c    = '0;
        if (bus.endereco_leitura1 != '0) begin
            if (escrita_ok_c && (bus.endereco_escrita == bus.endereco_leitura1))
                leitura1_c = bus.dado_escrita;
            else
                leitura1_c = regs[bus.endereco_leitura1];
        end
        if (bus.endereco_leitura2 != '0) begin
            if (escrita_ok_c && (bus.endereco_escrita == bus.endereco_leitura2))
                leitura2_c = bus.dado_escrita;
            else
                leitura2_c = regs[bus.endereco_leitura2];
        end
        if (bus.endereco_debug != '0) begin
            if (escrita_ok_c && (bus.endereco_escrita == bus.endereco_debug))
                debug_c = bus.dado_escrita;
            else
                debug_c = regs[bus.endereco_debug];
        end
    end

    // Storage and registered outputs; reset takes precedence over any access.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
            bus.leitura1       <= '0;
            bus.leitura2       <= '0;
            bus.saida_debug    <= '0;
            bus.escrita_valida <= 1'b0;
        end else begin
            if (escrita_ok_c) begin
                regs[bus.endereco_escrita] <= bus.dado_escrita;
            end
            if (bus.flag_leitura) begin
                bus.leitura1 <= leitura1_c;
                bus.leitura2 <= leitura2_c;
            end
            bus.saida_debug    <= debug_c;
            bus.escrita_valida <= escrita_ok_c;
        end
    end
endmodule

// File: tb/tb_banco_registradores.sv
// Randomized scoreboard bench for banco_registradores against an array-based reference model.
module tb_banco_registradores;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREG   = 2 ** ADDR_W;

    logic clock = 1'b0;
    logic reset = 1'b1;

    banco_registradores_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    banco_registradores #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned       cyc;
        logic [DATA_W-1:0] l1;
        logic [DATA_W-1:0] l2;
        logic [DATA_W-1:0] dbg;
        logic              ev;
    } exp_t;

    exp_t        sb [$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state: register contents and last read-port values.
    logic [DATA_W-1:0] mreg [NREG];
    logic [DATA_W-1:0] m_l1 = '0;
    logic [DATA_W-1:0] m_l2 = '0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a, input logic we,
                                                    input logic [ADDR_W-1:0] wa,
                                                    input logic [DATA_W-1:0] wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return mreg[a];
    endfunction

    // Drive one cycle of inputs and push what the outputs must show after the next edge.
    task automatic step(input logic rst, input logic we, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd, input logic re,
                        input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                        input logic [ADDR_W-1:0] ad);
        exp_t e;
        reset                 = rst;
        bus.flag_escrita      = we;
        bus.endereco_escrita  = wa;
        bus.dado_escrita      = wd;
        bus.flag_leitura      = re;
        bus.endereco_leitura1 = a1;
        bus.endereco_leitura2 = a2;
        bus.endereco_debug    = ad;
        e.cyc = cyc + 1;
        if (rst) begin
            for (int i = 0; i < NREG; i++) mreg[i] = '0;
            m_l1 = '0; m_l2 = '0;
            e.dbg = '0; e.ev = 1'b0;
        end else begin
            if (re) begin
                m_l1 = model_read(a1, we, wa, wd);
                m_l2 = model_read(a2, we, wa, wd);
            end
            e.dbg = model_read(ad, we, wa, wd);
            e.ev  = we && (wa != 0);
            if (e.ev) mreg[wa] = wd;
        end
        e.l1 = m_l1;
        e.l2 = m_l2;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the expectation tagged for this cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            exp_t old;
            old = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL sb_missed cyc=%0d got=none expected_cyc=%0d", cyc, old.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("leitura1", bus.leitura1, e.l1);
            chk("leitura2", bus.leitura2, e.l2);
            chk("saida_debug", bus.saida_debug, e.dbg);
            chk("escrita_valida", DATA_W'(bus.escrita_valida), DATA_W'(e.ev));
        end
    end

    initial begin
        logic [ADDR_W-1:0] a1, a2, ad, wa;
        logic              we, re, rst;
        logic [DATA_W-1:0] wd;
        for (int i = 0; i < NREG; i++) mreg[i] = '0;
        bus.flag_escrita = 1'b0; bus.endereco_escrita = '0; bus.dado_escrita = '0;
        bus.flag_leitura = 1'b0; bus.endereco_leitura1 = '0; bus.endereco_leitura2 = '0;
        bus.endereco_debug = '0;
        @(posedge clock);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 32'h1111_1111, 1, 3, 3, 3);

        // Reset contents: every address reads zero on both ports.
        for (int i = 0; i < NREG; i++)
            step(0, 0, 0, 0, 1, ADDR_W'(i), ADDR_W'(NREG - 1 - i), ADDR_W'(i));

        // Write then read r5; r0 on port 2.
        step(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5);
        step(0, 0, 0, 0, 1, 5, 0, 5);
        // Same-cycle bypass on both ports and debug.
        step(0, 1, 7, 32'h1234_5678, 1, 7, 7, 7);
        step(0, 0, 0, 0, 1, 7, 5, 7);
        // Writes to r0 are ignored, even with a concurrent read of r0.
        step(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        // Read hold while addresses change.
        step(0, 1, 3, 32'h0000_000A, 1, 5, 7, 3);
        step(0, 0, 0, 0, 0, 3, 3, 1);
        step(0, 0, 0, 0, 0, 9, 0, 2);
        step(0, 0, 0, 0, 1, 3, 3, 3);
        // Reset wins over a simultaneous write.
        step(0, 1, 9, 32'h0000_0055, 1, 9, 9, 9);
        step(1, 1, 9, 32'h0000_00AA, 1, 9, 9, 9);
        step(0, 0, 0, 0, 1, 9, 9, 9);
        step(0, 1, 9, 32'h0000_00BB, 0, 9, 9, 9);
        step(0, 0, 0, 0, 1, 9, 3, 9);

        // Random traffic biased toward address collisions.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            we  = ($urandom_range(0, 1) == 1);
            re  = ($urandom_range(0, 3) != 0);
            wd  = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                wa = ADDR_W'($urandom_range(0, 3));
                a1 = ADDR_W'($urandom_range(0, 3));
                a2 = ADDR_W'($urandom_range(0, 3));
                ad = ADDR_W'($urandom_range(0, 3));
            end else begin
                wa = ADDR_W'($urandom);
                a1 = ADDR_W'($urandom);
                a2 = ADDR_W'($urandom);
                ad = ADDR_W'($urandom);
            end
            step(rst, we, wa, wd, re, a1, a2, ad);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clock);
        #2;
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain got=%0d_pending expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/banco_registradores.md
BANCO_REGISTRADORES -- requirements
Module: banco_registradores

Interface
REQ-001 Parameter DATA_W, default 32, data word width; the write-back data width of the processor.
REQ-002 Parameter ADDR_W, default 5, register address width; register count is 2**ADDR_W.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 flag_escrita  input  1  write enable for the write port.
REQ-006 endereco_escrita  input  ADDR_W  destination register address.
REQ-007 dado_escrita  input  DATA_W  write data, driven by the write-back multiplexer output.
REQ-008 flag_leitura  input  1  read enable; when 0, read outputs hold.
REQ-009 endereco_leitura1  input  ADDR_W  source address, port 1.
REQ-010 endereco_leitura2  input  ADDR_W  source address, port 2.
REQ-011 leitura1  output  DATA_W  registered read data, port 1.
REQ-012 leitura2  output  DATA_W  registered read data, port 2.
REQ-013 endereco_debug  input  ADDR_W  register selected for the display/debug port.
REQ-014 saida_debug  output  DATA_W  registered contents of the debug-selected register.
REQ-015 escrita_valida  output  1  pulses 1 for one cycle after each accepted write to a nonzero address.

Function
REQ-016 Storage: 2**ADDR_W registers of DATA_W bits; register 0 reads as 0 at all times.
REQ-017 Write: on rising edge with flag_escrita=1 and endereco_escrita!=0, register[endereco_escrita] <= dado_escrita.
REQ-018 Write to address 0 with flag_escrita=1: no storage change; escrita_valida stays 0.
REQ-019 escrita_valida: registered; equals (flag_escrita and endereco_escrita!=0) of the previous cycle.
REQ-020 Read latency: exactly 1 cycle; when flag_leitura=1, leituraN on cycle N+1 reflects the register addressed on cycle N.
REQ-021 Read hold: when flag_leitura=0, leitura1 and leitura2 retain their previous values.
REQ-022 Write-first bypass: same-cycle write and read of the same nonzero address; the read port returns dado_escrita, not the old contents.
REQ-023 Bypass applies independently to both read ports; both ports may address the same register.
REQ-024 Read of address 0 returns 0 even if a write to address 0 occurs in the same cycle.
REQ-025 saida_debug: updated every cycle (no enable), 1-cycle latency, same write-first bypass and zero rule as the read ports.
REQ-026 No combinational path from any input to any output.
REQ-027 Writes and reads to distinct addresses in the same cycle are fully independent.

Reset
REQ-028 With reset=1 at a rising edge, all registers clear to 0, leitura1, leitura2 and saida_debug become 0, and escrita_valida becomes 0.
REQ-029 Reset has priority over a simultaneous write or read; the write is discarded.
REQ-030 Reset during an ongoing write sequence: the in-flight write is lost; the first write accepted is the one on the first edge with reset=0.
REQ-031 All storage has a defined value after one reset cycle; no X may appear on any output after reset.

Verification
REQ-032 Reset, then read all addresses on both ports -> every leitura1/leitura2 is 0 one cycle later.
REQ-033 Write 0xDEADBEEF to r5, next cycle read r5 on port 1 and r0 on port 2 -> leitura1=0xDEADBEEF, leitura2=0, escrita_valida=1 in the cycle after the write.
REQ-034 Write 0x12345678 to r7 while reading r7 on both ports in the same cycle -> both outputs 0x12345678 next cycle (bypass).
REQ-035 Write 0xFFFFFFFF to r0, then read r0 -> 0; escrita_valida remains 0.
REQ-036 Load r3=0x0000000A, hold flag_leitura=0 while changing addresses -> outputs hold previous values; set flag_leitura=1 -> r3 value appears next cycle.
REQ-037 Write r9=0x55, assert reset concurrently with a write r9=0xAA, then read r9 -> 0; saida_debug with endereco_debug=9 -> 0.
